// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice: widths, the fetch-entry
// record and the queue occupancy classification.
package instruction_fetch_pkg;

    localparam int          INST_W           = 32;
    localparam int          WADDR_W          = 30;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } queue_state_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Synchronous FIFO of fetch entries; flush overrides push and pop in the same cycle.
module instruction_fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full,
    output logic         empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign rd_entry  = mem_r[rd_ptr_r];
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and queues {pc, inst} pairs
// for decode; redirects reload the PC and discard everything queued.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic [WADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0]  imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    output logic [INST_W-1:0]  inst,
    output logic [31:0]        inst_pc,
    input  logic               inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      pc_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    fetch_entry_t     wr_entry_s;
    fetch_entry_t     head_s;
    queue_state_t     qstate_s;

    assign imem_addr  = pc_r[31:2];
    assign wr_entry_s = '{pc: pc_r, inst: imem_data};
    assign inst_valid = (qstate_s != Q_EMPTY);
    assign pop_s      = inst_valid & inst_ready;
    assign push_s     = enable & ~redirect_valid & ((count_s < CNT_W'(DEPTH)) | pop_s);

    instruction_fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (redirect_valid),
        .wr_entry (wr_entry_s),
        .rd_entry (head_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (count_s)
    );

    // Classify queue occupancy.
    always_comb begin
        qstate_s = Q_PARTIAL;
        case ({full_s, empty_s})
            2'b01:   qstate_s = Q_EMPTY;
            2'b10:   qstate_s = Q_FULL;
            default: qstate_s = Q_PARTIAL;
        endcase
    end

    // Head presentation; zeroed whenever nothing is queued.
    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (inst_valid) begin
            inst    = head_s.inst;
            inst_pc = head_s.pc;
        end else begin
            inst    = '0;
            inst_pc = '0;
        end
    end

    // Program counter: redirect beats sequential advance; wraps silently at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
        end else if (push_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory word at index i (from 0x00400000) holds 11*(i+1).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [29:0] idx;
        idx = addr[31:2] - 30'h0010_0000;
        return 32'd11 * ({2'b00, idx} + 32'd1);
    endfunction

    assign imem_data = mem_word({imem_addr, 2'b00});

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0040_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic rdy);
        reset = 1'b0;
        redirect_valid = 1'b0;
        enable = en;
        inst_ready = rdy;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        inst_ready = 1'b1;
        step();
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        tests++; if (inst !== 32'd0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst); end
        tests++; if (inst_pc !== 32'd0) begin fails++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        tests++; if (imem_addr !== 30'h0010_0000) begin fails++; $display("FAIL reset_addr: got %h want 100000", imem_addr); end
        reset = 1'b1;
        step();
        tests++; if (inst_valid !== 1'b1 || inst !== 32'd11 || inst_pc !== 32'h0040_0000) begin fails++; $display("FAIL first_fetch: got %b %0d %h want 1 11 00400000", inst_valid, inst, inst_pc); end
        step();
        tests++; if (inst !== 32'd22 || inst_pc !== 32'h0040_0004) begin fails++; $display("FAIL second_fetch: got %0d %h want 22 00400004", inst, inst_pc); end
        step();
        tests++; if (inst !== 32'd33 || inst_pc !== 32'h0040_0008) begin fails++; $display("FAIL third_fetch: got %0d %h want 33 00400008", inst, inst_pc); end
    endtask

    task automatic test_fill_and_stream();
        logic [31:0] exp_pc;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step();
        tests++; if (imem_addr !== 30'h0010_0004) begin fails++; $display("FAIL fill_addr: got %h want 100004", imem_addr); end
        tests++; if (inst_valid !== 1'b1 || inst !== 32'd11 || inst_pc !== 32'h0040_0000) begin fails++; $display("FAIL fill_head: got %b %0d %h want 1 11 00400000", inst_valid, inst, inst_pc); end
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_pc = 32'h0040_0004 + 32'd4 * k;
            tests++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin fails++; $display("FAIL stream_%0d: got %b %h %0d want 1 %h %0d", k, inst_valid, inst_pc, inst, exp_pc, mem_word(exp_pc)); end
            tests++; if ({imem_addr, 2'b00} !== 32'h0040_0014 + 32'd4 * k) begin fails++; $display("FAIL stream_pc_%0d: got %h want %h", k, {imem_addr, 2'b00}, 32'h0040_0014 + 32'd4 * k); end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        step(); step(); step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0023;
        step();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redirect_flush: got %b want 0", inst_valid); end
        tests++; if (imem_addr !== 30'h0010_0008) begin fails++; $display("FAIL redirect_pc: got %h want 100008", imem_addr); end
        step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0020 || inst !== 32'd99) begin fails++; $display("FAIL redirect_target: got %b %h %0d want 1 00400020 99", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_back_to_back_redirect();
        do_reset(1'b1, 1'b1);
        step(); step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0100;
        step();
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 30'h0010_0040) begin fails++; $display("FAIL b2b_first: got %b %h want 0 100040", inst_valid, imem_addr); end
        redirect_pc = 32'h0040_0040;
        step();
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 30'h0010_0010) begin fails++; $display("FAIL b2b_second: got %b %h want 0 100010", inst_valid, imem_addr); end
        redirect_valid = 1'b0;
        step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0040 || inst !== 32'd187) begin fails++; $display("FAIL b2b_target: got %b %h %0d want 1 00400040 187", inst_valid, inst_pc, inst); end
        step();
        tests++; if (inst_pc !== 32'h0040_0044 || inst !== 32'd198) begin fails++; $display("FAIL b2b_next: got %h %0d want 00400044 198", inst_pc, inst); end
    endtask

    task automatic test_enable();
        do_reset(1'b0, 1'b1);
        step(); step(); step();
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 30'h0010_0000) begin fails++; $display("FAIL disabled_hold: got %b %h want 0 100000", inst_valid, imem_addr); end
        enable = 1'b1;
        inst_ready = 1'b0;
        step(); step();
        enable = 1'b0;
        inst_ready = 1'b1;
        step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0004 || imem_addr !== 30'h0010_0002) begin fails++; $display("FAIL drain_head: got %b %h %h want 1 00400004 100002", inst_valid, inst_pc, imem_addr); end
        step();
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b want 0", inst_valid); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b0);
        step(); step();
        #2;
        reset = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 30'h0010_0000) begin fails++; $display("FAIL async_reset: got %b %h want 0 100000", inst_valid, imem_addr); end
        inst_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0000 || inst !== 32'd11) begin fails++; $display("FAIL restart: got %b %h %0d want 1 00400000 11", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_pc_wrap();
        do_reset(1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        tests++; if (imem_addr !== 30'h3FFF_FFFF) begin fails++; $display("FAIL wrap_load: got %h want 3fffffff", imem_addr); end
        step();
        tests++; if (imem_addr !== 30'h0 || inst_pc !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin fails++; $display("FAIL wrap_zero: got %h %h %b want 0 fffffffc 1", imem_addr, inst_pc, inst_valid); end
        step();
        tests++; if (inst_pc !== 32'h0 || imem_addr !== 30'h1) begin fails++; $display("FAIL wrap_next: got %h %h want 0 1", inst_pc, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_fill_and_stream();
        test_redirect();
        test_back_to_back_redirect();
        test_enable();
        test_async_reset();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
